// File: rtl/channel_packer.sv
// Gathers one PE_NUM*WIDTH slice per channel (any order) into a packed IN_CH-wide word; 1-cycle accept-to-valid.
// Holds the word while i_ready is low and accepts no slices until handoff; a protocol error gives a one-cycle o_err pulse.
module channel_packer #(
    parameter int WIDTH  = 30,
    parameter int IN_CH  = 3,
    parameter int PE_NUM = 2
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [WIDTH*PE_NUM-1:0]         i_data,
    input  logic [$clog2(IN_CH):0]          i_ch_sel,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [IN_CH*PE_NUM*WIDTH-1:0]   o_data,
    output logic                            o_err
);
    localparam int SLICE = PE_NUM * WIDTH;
    localparam int CH_W  = $clog2(IN_CH) + 1;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [IN_CH-1:0]               r_mask;
    logic [IN_CH-1:0]               w_mask_nxt;
    logic [IN_CH-1:0]               w_sel;
    logic [IN_CH*PE_NUM*WIDTH-1:0]  r_data;
    logic                           r_err;
    logic                           w_accept;
    logic                           w_in_range;
    logic                           w_dup;
    logic                           w_err_nxt;

    // One-hot slot decode; an out-of-range index decodes to all zeros.
    always_comb begin
        w_sel = '0;
        for (int c = 0; c < IN_CH; c++) begin
            w_sel[c] = (i_ch_sel == CH_W'(c));
        end
    end

    assign w_accept   = i_valid && (r_state == FILL);
    assign w_in_range = |w_sel;
    assign w_dup      = |(w_sel & r_mask);
    assign w_err_nxt  = w_accept && (!w_in_range || w_dup);

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        case (r_state)
            FILL: begin
                if (w_accept) begin
                    w_mask_nxt = r_mask | w_sel;
                    if (&w_mask_nxt) begin
                        w_state_nxt = FULL;
                    end
                end
            end
            FULL: begin
                if (i_ready) begin
                    w_mask_nxt  = '0;
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    // Slot contents survive handoff; consumers qualify with o_valid.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= FILL;
            r_mask  <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_err   <= w_err_nxt;
            for (int c = 0; c < IN_CH; c++) begin
                if (w_accept && w_sel[c]) begin
                    r_data[c*SLICE +: SLICE] <= i_data;
                end
            end
        end
    end

    assign o_ready = (r_state == FILL);
    assign o_valid = (r_state == FULL);
    assign o_data  = r_data;
    assign o_err   = r_err;
endmodule

// File: tb/tb_channel_packer.sv
// Scoreboard bench for channel_packer: a slot model pushes each completed word, popped when o_valid is seen.
module tb_channel_packer;
    localparam int WIDTH  = 30;
    localparam int IN_CH  = 3;
    localparam int PE_NUM = 2;
    localparam int SLICE  = WIDTH * PE_NUM;
    localparam int DW     = IN_CH * SLICE;
    localparam int CW     = $clog2(IN_CH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_valid = 1'b0;
    logic             i_ready = 1'b0;
    logic [SLICE-1:0] i_data = '0;
    logic [CW-1:0]    i_ch_sel = '0;
    logic             o_ready;
    logic             o_valid;
    logic             o_err;
    logic [DW-1:0]    o_data;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0]    exp_q[$];
    logic [DW-1:0]    m_data = '0;
    logic [IN_CH-1:0] m_mask = '0;
    bit               m_full = 1'b0;

    channel_packer #(.WIDTH(WIDTH), .IN_CH(IN_CH), .PE_NUM(PE_NUM)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_ch_sel(i_ch_sel), .o_valid(o_valid),
        .i_ready(i_ready), .o_data(o_data), .o_err(o_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        m_mask = '0;
        m_data = '0;
        m_full = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_handoff();
        m_mask = '0;
        m_full = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one slice for one cycle and applies it to the model at the edge.
    task automatic send(input int ch, input logic [SLICE-1:0] d);
        i_valid  = 1'b1;
        i_ch_sel = CW'(ch);
        i_data   = d;
        @(posedge clk);
        if (!m_full && ch < IN_CH) begin
            m_data[ch*SLICE +: SLICE] = d;
            m_mask[ch] = 1'b1;
            if (&m_mask) begin
                exp_q.push_back(m_data);
                m_full = 1'b1;
            end
        end
        #1;
        i_valid = 1'b0;
    endtask

    function automatic logic [SLICE-1:0] rnd_slice();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[SLICE-1:0];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #2;
        total++;
        if ({o_valid, o_ready, o_err} !== 3'b010) begin
            bad++; $display("FAIL reset_ctl got=%b want=010", {o_valid, o_ready, o_err});
        end
        total++;
        if (o_data !== '0) begin
            bad++; $display("FAIL reset_data got=%h want=0", o_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        idle(1);
        total++;
        if ({o_valid, o_ready, o_err} !== 3'b010) begin
            bad++; $display("FAIL post_reset_ctl got=%b want=010", {o_valid, o_ready, o_err});
        end
    endtask

    task automatic test_in_order();
        logic [DW-1:0] k;
        logic [DW-1:0] e;
        k = {30'h5, 30'h6, 30'h3, 30'h4, 30'h1, 30'h2};
        i_ready = 1'b1;
        send(0, {30'h1, 30'h2});
        send(1, {30'h3, 30'h4});
        total++;
        if (o_valid !== 1'b0) begin
            bad++; $display("FAIL inorder_early_valid got=%b want=0", o_valid);
        end
        send(2, {30'h5, 30'h6});
        total++;
        if ({o_valid, o_ready} !== 2'b10) begin
            bad++; $display("FAIL inorder_valid got=%b want=10", {o_valid, o_ready});
        end
        e = exp_q.pop_front();
        total++;
        if (o_data !== e) begin
            bad++; $display("FAIL inorder_data got=%h want=%h", o_data, e);
        end
        total++;
        if (o_data !== k) begin
            bad++; $display("FAIL inorder_layout got=%h want=%h", o_data, k);
        end
        idle(1);
        model_handoff();
        total++;
        if ({o_valid, o_ready} !== 2'b01) begin
            bad++; $display("FAIL inorder_handoff got=%b want=01", {o_valid, o_ready});
        end
    endtask

    task automatic test_out_of_order();
        logic [DW-1:0] k;
        logic [DW-1:0] e;
        k = {30'h5, 30'h6, 30'h3, 30'h4, 30'h1, 30'h2};
        i_ready = 1'b1;
        send(2, {30'h5, 30'h6});
        idle($urandom_range(0, 3));
        total++;
        if (o_valid !== 1'b0) begin
            bad++; $display("FAIL ooo_valid1 got=%b want=0", o_valid);
        end
        send(0, {30'h1, 30'h2});
        idle($urandom_range(0, 3));
        total++;
        if (o_valid !== 1'b0) begin
            bad++; $display("FAIL ooo_valid2 got=%b want=0", o_valid);
        end
        send(1, {30'h3, 30'h4});
        total++;
        if (o_valid !== 1'b1) begin
            bad++; $display("FAIL ooo_valid3 got=%b want=1", o_valid);
        end
        e = exp_q.pop_front();
        total++;
        if (o_data !== e || o_data !== k) begin
            bad++; $display("FAIL ooo_data got=%h want=%h", o_data, k);
        end
        idle(1);
        model_handoff();
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        send(0, rnd_slice());
        send(1, rnd_slice());
        send(2, rnd_slice());
        for (int i = 0; i < 5; i++) begin
            i_valid  = 1'b1;
            i_ch_sel = '0;
            i_data   = '1;
            @(posedge clk);
            #1;
            total++;
            if ({o_valid, o_ready, o_err} !== 3'b100 || o_data !== exp_q[0]) begin
                bad++; $display("FAIL hold_%0d ctl=%b data=%h want ctl=100 data=%h",
                                i, {o_valid, o_ready, o_err}, o_data, exp_q[0]);
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        void'(exp_q.pop_front());
        idle(1);
        model_handoff();
        total++;
        if ({o_valid, o_ready} !== 2'b01) begin
            bad++; $display("FAIL hold_release got=%b want=01", {o_valid, o_ready});
        end
    endtask

    task automatic test_duplicate();
        logic [SLICE-1:0] a;
        logic [SLICE-1:0] b;
        logic [DW-1:0]    e;
        a = rnd_slice();
        b = ~a;
        i_ready = 1'b1;
        send(1, a);
        total++;
        if (o_err !== 1'b0) begin
            bad++; $display("FAIL dup_first_err got=%b want=0", o_err);
        end
        send(1, b);
        total++;
        if (o_err !== 1'b1) begin
            bad++; $display("FAIL dup_err got=%b want=1", o_err);
        end
        idle(1);
        total++;
        if ({o_err, o_valid} !== 2'b00) begin
            bad++; $display("FAIL dup_pulse got=%b want=00", {o_err, o_valid});
        end
        send(0, rnd_slice());
        send(2, rnd_slice());
        e = exp_q.pop_front();
        total++;
        if (o_valid !== 1'b1 || o_data !== e || o_data[SLICE +: SLICE] !== b) begin
            bad++; $display("FAIL dup_frame valid=%b data=%h want=%h", o_valid, o_data, e);
        end
        idle(1);
        model_handoff();
    endtask

    task automatic test_bad_channel();
        logic [DW-1:0] e;
        i_ready = 1'b1;
        send(3, rnd_slice());
        total++;
        if ({o_err, o_valid, o_ready} !== 3'b101 || o_data !== m_data) begin
            bad++; $display("FAIL badch3 ctl=%b data=%h want ctl=101 data=%h",
                            {o_err, o_valid, o_ready}, o_data, m_data);
        end
        send(7, rnd_slice());
        total++;
        if (o_err !== 1'b1 || o_data !== m_data) begin
            bad++; $display("FAIL badch7 err=%b data=%h want err=1 data=%h", o_err, o_data, m_data);
        end
        send(0, rnd_slice());
        send(1, rnd_slice());
        total++;
        if ({o_err, o_valid} !== 2'b00) begin
            bad++; $display("FAIL badch_mask got=%b want=00", {o_err, o_valid});
        end
        send(2, rnd_slice());
        e = exp_q.pop_front();
        total++;
        if (o_valid !== 1'b1 || o_data !== e) begin
            bad++; $display("FAIL badch_frame valid=%b data=%h want=%h", o_valid, o_data, e);
        end
        idle(1);
        model_handoff();
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] e;
        i_ready = 1'b1;
        send(0, rnd_slice());
        send(1, rnd_slice());
        #4;
        rst = 1'b1;
        #1;
        total++;
        if ({o_valid, o_ready} !== 2'b01 || o_data !== '0) begin
            bad++; $display("FAIL midrst ctl=%b data=%h want ctl=01 data=0", {o_valid, o_ready}, o_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        send(2, rnd_slice());
        idle(1);
        total++;
        if (o_valid !== 1'b0) begin
            bad++; $display("FAIL midrst_partial got=%b want=0", o_valid);
        end
        send(0, rnd_slice());
        send(1, rnd_slice());
        e = exp_q.pop_front();
        total++;
        if (o_valid !== 1'b1 || o_data !== e) begin
            bad++; $display("FAIL midrst_frame valid=%b data=%h want=%h", o_valid, o_data, e);
        end
        idle(1);
        model_handoff();

        i_ready = 1'b0;
        send(0, rnd_slice());
        send(1, rnd_slice());
        send(2, rnd_slice());
        total++;
        if (o_valid !== 1'b1) begin
            bad++; $display("FAIL fullrst_pre got=%b want=1", o_valid);
        end
        #4;
        rst = 1'b1;
        #1;
        total++;
        if ({o_valid, o_ready} !== 2'b01 || o_data !== '0) begin
            bad++; $display("FAIL fullrst ctl=%b data=%h want ctl=01 data=0", {o_valid, o_ready}, o_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e;
        i_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            send(1, rnd_slice());
            send(2, rnd_slice());
            send(0, rnd_slice());
            e = exp_q.pop_front();
            total++;
            if (o_valid !== 1'b1 || o_data !== e) begin
                bad++; $display("FAIL b2b_%0d valid=%b data=%h want=%h", f, o_valid, o_data, e);
            end
            idle(1);
            model_handoff();
            total++;
            if (o_ready !== 1'b1) begin
                bad++; $display("FAIL b2b_ready_%0d got=%b want=1", f, o_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_out_of_order();
        test_backpressure();
        test_duplicate();
        test_bad_channel();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
